alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Initiator side of the 5-bit four-operation ALU interface (op 00 ADD, 01 SUB, 10 AND, 11 OR).
- Accepts commands over a valid/ready port and keeps a 5-bit accumulator as ALU operand A.
- Drives the external combinational ALU's a/b/op inputs, captures its result back into the accumulator, and returns the result with flags over a valid/ready response port.
- Sits between the vending-machine control FSM and the ALU, for example for credit accumulation and price subtraction.

Parameters:
- W, 5, datapath width of the accumulator, operands and ALU result.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver can accept a command.
- cmd_load  in  1  1 = load cmd_operand into the accumulator with no ALU operation; 0 = perform ALU op.
- cmd_op  in  2  ALU opcode, ignored when cmd_load=1.
- cmd_operand  in  W  operand B, or the load value.
- alu_a  out  W  to ALU input a.
- alu_b  out  W  to ALU input b.
- alu_op  out  2  to ALU op.
- alu_result  in  W  from ALU result (combinational).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  W  accumulator value after the command.
- rsp_zero  out  1  rsp_data == 0.
- rsp_carry  out  1  ADD carry-out or SUB borrow; 0 for AND, OR and load.
- op_count  out  CNT_W  number of completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset: the synchronous rst wins over every other input in the same cycle and may be asserted in any state.
  - State returns to IDLE.
  - Accumulator, alu_a, alu_b, alu_op, rsp_data, rsp_zero, rsp_carry and op_count all go to 0.
  - rsp_valid = 0 and cmd_ready = 1 on the first cycle after reset.
  - Any in-flight command is discarded and no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - A command is accepted when cmd_valid & cmd_ready at a rising edge.
  - On an ALU command: latch alu_a <= acc, alu_b <= cmd_operand, alu_op <= cmd_op, then go to EXEC.
  - On a load command: acc <= cmd_operand, rsp_carry <= 0, go straight to RESP. alu_* outputs are unchanged.
- EXEC (exactly one cycle):
  - cmd_ready = 0.
  - alu_a, alu_b and alu_op are stable for the whole cycle.
  - At the closing edge: acc <= alu_result; rsp_carry <= computed flag; go to RESP.
- Carry flag is computed inside the driver from the latched alu_a and alu_b, not from the ALU:
  - ADD: bit W of the (W+1)-bit zero-extended sum.
  - SUB: 1 when alu_a < alu_b, unsigned.
  - AND/OR: 0.
- RESP:
  - rsp_valid = 1, rsp_data = acc, rsp_zero = (acc == 0); cmd_ready = 0.
  - rsp_data and the flags are held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: op_count increments (wrapping 2^CNT_W-1 -> 0) and the FSM goes to IDLE.
  - rsp_valid drops in the next cycle.
- Latency, accept edge T to rsp_valid high:
  - ALU command: rsp_valid is high in the cycle after edge T+1, i.e. 2 cycles.
  - Load: rsp_valid is high after edge T, i.e. 1 cycle.
  - Minimum issue interval with rsp_ready tied high: 3 cycles for ALU commands, 2 cycles for loads.
- No back-to-back acceptance: a command presented while in EXEC or RESP stays pending. The source must hold cmd_valid and the command fields stable until accepted.
- rsp_data and the flags hold their last values after the RESP handshake until the next response.
- alu_* outputs hold their last issued values between commands.
- Arithmetic wraps modulo 2^W, e.g. 31 + 1 = 0 with carry 1, and 3 - 5 = 30 with borrow 1.
- The driver does not check alu_result; a wrong ALU result is passed through unchanged.

Test Plan:
- Reset then load 12 -> rsp_valid one cycle after accept, rsp_data = 12, zero = 0, carry = 0, op_count = 1.
- After load 20, ADD 15 with a reference ALU model -> alu_a = 20, alu_b = 15, alu_op = 00 during EXEC; response data = 3, carry = 1, valid 2 cycles after accept.
- Acc = 3, SUB 5 -> data = 30, carry = 1. Then SUB 30 -> data = 0, zero = 1, carry = 0.
- Acc = 22 (10110), AND 13 (01101) -> data = 4, carry = 0. Then OR 9 -> data = 13.
- Backpressure: hold rsp_ready = 0 for 5 cycles with cmd_valid held high and a second command waiting.
  - rsp_data and the flags stay stable and cmd_ready stays 0.
  - The second command is accepted exactly one cycle after the rsp handshake.
- Assert rst during EXEC of ADD 7 -> no response, acc = 0, op_count = 0, cmd_ready = 1 the next cycle. Also run 256 loads -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Initiator for a 4-operation combinational ALU: accepts load/ALU commands,
// keeps the accumulator as operand A and returns result plus zero/carry flags.
module alu_cmd_driver #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_operand,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     alu_a_q;
    logic [W-1:0]     alu_b_q;
    logic [1:0]       alu_op_q;
    logic             rsp_zero_q;
    logic             rsp_carry_q;
    logic [CNT_W-1:0] op_count_q;
    logic [W:0]       sum_w;
    logic             carry_d;

    // Flag derives from the latched operands, not from the external ALU.
    always_comb begin
        sum_w = {1'b0, alu_a_q} + {1'b0, alu_b_q};
        case (alu_op_q)
            2'b00:   carry_d = sum_w[W];
            2'b01:   carry_d = (alu_a_q < alu_b_q);
            default: carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc_q       <= cmd_operand;
                            rsp_zero_q  <= (cmd_operand == '0);
                            rsp_carry_q <= 1'b0;
                            state_q     <= RESP;
                        end else begin
                            alu_a_q  <= acc_q;
                            alu_b_q  <= cmd_operand;
                            alu_op_q <= cmd_op;
                            state_q  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc_q       <= alu_result;
                    rsp_zero_q  <= (alu_result == '0);
                    rsp_carry_q <= carry_d;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count_q <= op_count_q + CNT_W'(1);
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Accumulator only changes on entry to RESP, so it doubles as rsp_data.
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = acc_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed plus randomized bench for alu_cmd_driver with an integer reference model.
module tb_alu_cmd_driver;

    localparam int W     = 5;
    localparam int CNT_W = 8;
    localparam int MOD   = 1 << W;
    localparam int CMOD  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_load = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [W-1:0]     cmd_operand = '0;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [1:0]       alu_op;
    logic [W-1:0]     alu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [W-1:0]     rsp_data;
    logic             rsp_zero;
    logic             rsp_carry;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int m_acc    = 0;
    int m_cnt    = 0;

    alu_cmd_driver #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_operand(cmd_operand),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_op(input int ld, input int op, input int a, input int b,
                          output int d, output int c);
        if (ld != 0) begin
            d = b; c = 0;
        end else begin
            case (op)
                0: begin d = (a + b) % MOD; c = ((a + b) >= MOD) ? 1 : 0; end
                1: begin d = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
                2: begin d = a & b; c = 0; end
                default: begin d = a | b; c = 0; end
            endcase
        end
    endtask

    // Issue one command, check EXEC-phase operands, latency, flags, hold under
    // 'hold' cycles of backpressure, and the handshake/counter afterwards.
    task automatic send(input int ld, input int op, input int opd, input int hold);
        int exp_d, exp_c, cyc;
        ref_op(ld, op, m_acc, opd, exp_d, exp_c);
        cmd_valid   = 1'b1;
        cmd_load    = (ld != 0);
        cmd_op      = op[1:0];
        cmd_operand = opd[W-1:0];
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (ld == 0) begin
            chk("exec_cmd_ready", cmd_ready, 0);
            chk("exec_rsp_valid", rsp_valid, 0);
            chk("exec_alu_a", alu_a, m_acc);
            chk("exec_alu_b", alu_b, opd);
            chk("exec_alu_op", alu_op, op);
            @(negedge clk);
        end
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, exp_d);
            chk("rsp_zero", rsp_zero, (exp_d == 0) ? 1 : 0);
            chk("rsp_carry", rsp_carry, exp_c);
            chk("rsp_cmd_ready", cmd_ready, 0);
            if (i < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_acc = exp_d;
        m_cnt = (m_cnt + 1) % CMOD;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_op_count", op_count, m_cnt);
        chk("post_data_hold", rsp_data, exp_d);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_zero", rsp_zero, 0);
        chk("reset_rsp_carry", rsp_carry, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_alu_op", alu_op, 0);

        send(1, 0, 12, 0);
        chk("load12_count", op_count, 1);
        send(1, 0, 20, 0);
        send(0, 0, 15, 0);
        chk("add_wrap_data", rsp_data, 3);
        send(0, 1, 5, 1);
        chk("sub_borrow_data", rsp_data, 30);
        send(0, 1, 30, 0);
        chk("sub_zero_flag", rsp_zero, 1);
        send(1, 0, 22, 0);
        send(0, 2, 13, 0);
        chk("and_data", rsp_data, 4);
        send(0, 3, 9, 0);
        chk("or_data", rsp_data, 13);
        send(1, 0, 31, 0);
        send(0, 0, 1, 0);
        chk("add_31_1_carry", rsp_carry, 1);

        // Backpressure with a second command pending
        send(1, 0, 5, 0);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b00; cmd_operand = 5'd3;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        @(negedge clk);
        cmd_op = 2'b11; cmd_operand = 5'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 8);
            chk("bp_rsp_flags", {rsp_zero, rsp_carry}, 0);
            chk("bp_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_after_hs_ready", cmd_ready, 1);
        chk("bp_after_hs_valid", rsp_valid, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_accepted", cmd_ready, 0);
        chk("bp_second_alu_a", alu_a, 8);
        chk("bp_second_alu_b", alu_b, 1);
        chk("bp_second_alu_op", alu_op, 3);
        @(negedge clk);
        chk("bp_second_data", rsp_data, 9);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_acc = 9;
        m_cnt = (m_cnt + 2) % CMOD;
        chk("bp_count", op_count, m_cnt);

        // Reset during EXEC
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b00; cmd_operand = 5'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_exec_state", {cmd_ready, rsp_valid}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_cmd_ready", cmd_ready, 1);
        chk("rst_exec_rsp_valid", rsp_valid, 0);
        chk("rst_exec_op_count", op_count, 0);
        chk("rst_exec_rsp_data", rsp_data, 0);
        @(negedge clk);
        chk("rst_exec_no_rsp", rsp_valid, 0);
        m_acc = 0;
        m_cnt = 0;
        send(0, 0, 0, 0);

        // Randomized commands against the reference model
        for (int n = 0; n < 40; n++) begin
            send(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 2)));
        end

        // Counter wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        for (int n = 0; n < 256; n++) send(1, 0, int'($urandom_range(0, MOD - 1)), 0);
        chk("op_count_wrap", op_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
